// File: rtl/otbn_pq_pkg.sv
// Shared types and constants for the bit-reversal permutation sequencer.
package otbn_pq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bitrev_seq_state_e;

  // Plain: r = bitrev(x). PqShift: 4*r, i.e. a word-index turned into a byte offset.
  typedef enum logic {
    BitrevOpPlain   = 1'b0,
    BitrevOpPqShift = 1'b1
  } bitrev_op_e;

  localparam int unsigned BitrevSeqMinLogN = 6;
  localparam int unsigned BitrevSeqMaxLogN = 12;

  typedef struct packed {
    logic [31:0] addr_a;
    logic [31:0] addr_b;
  } bitrev_pair_t;

endpackage

// File: rtl/bitrev_perm_seq_bitreverse.sv
// Reverses the low log_n bits of data_i; optionally scales the result by 4.
module bitrev_perm_seq_bitreverse
  import otbn_pq_pkg::*;
#(
  parameter int unsigned Width = 12
) (
  input  logic [Width-1:0] data_i,
  input  logic [3:0]       log_n_i,
  input  bitrev_op_e       op_i,
  output logic [Width+1:0] result_o
);

  logic [Width-1:0] rev_full;
  logic [Width-1:0] rev;
  logic [4:0]       sh;

  // Full-width mirror; data_i < 2^log_n so the reversed value sits in the top bits.
  for (genvar g = 0; g < Width; g++) begin : g_rev
    assign rev_full[g] = data_i[Width-1-g];
  end

  assign sh  = 5'(Width) - {1'b0, log_n_i};
  assign rev = rev_full >> sh;

  // Select plain or byte-scaled result.
  always_comb begin
    result_o = {2'b00, rev};
    if (op_i == BitrevOpPqShift) result_o = {rev, 2'b00};
  end

endmodule

// File: rtl/bitrev_perm_seq.sv
// Bit-reversal permutation pair sequencer. Walks i = 0 .. 2^log_n-1 and emits
// (base+4i, base+4*bitrev(i)) for every i < bitrev(i), one pair per cycle
// with ready/valid backpressure.
// Optional feature: define BITREV_SEQ_PAIR_CNT_EN to build the transfer counter
// on pair_cnt_o; otherwise pair_cnt_o is tied to zero.
module bitrev_perm_seq
  import otbn_pq_pkg::*;
#(
  parameter int unsigned MinLogN = BitrevSeqMinLogN,
  parameter int unsigned MaxLogN = BitrevSeqMaxLogN
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        clear_i,
  input  logic [3:0]  log_n_i,
  input  logic [31:0] base_addr_i,
  output logic        pair_valid_o,
  input  logic        pair_ready_i,
  output logic [31:0] addr_a_o,
  output logic [31:0] addr_b_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [11:0] pair_cnt_o
);

  // One extra index bit so "all indices evaluated" (i == 2^log_n) is representable.
  localparam int unsigned IdxW  = MaxLogN + 1;
  localparam logic [3:0]  MinL  = 4'(MinLogN);
  localparam logic [3:0]  MaxL  = 4'(MaxLogN);

  bitrev_seq_state_e state_q, state_d;
  logic [3:0]        log_n_q;
  logic [31:0]       base_q;
  logic [IdxW-1:0]   idx_q;
  logic [IdxW-1:0]   idx_end;

  logic [MaxLogN+1:0] r_plain_w;
  logic [MaxLogN+1:0] r_x4;
  logic [MaxLogN-1:0] r_plain;

  logic         len_ok, start_ok, err_d;
  logic         idx_last, stall, fire, eval, is_pair;
  bitrev_pair_t pair_d;

  assign len_ok   = (log_n_i >= MinL) && (log_n_i <= MaxL);
  assign idx_end  = {{(IdxW-1){1'b0}}, 1'b1} << log_n_q;
  assign idx_last = (idx_q == idx_end);
  assign stall    = pair_valid_o && !pair_ready_i;
  assign fire     = pair_valid_o && pair_ready_i;
  assign eval     = (state_q == RUN) && !clear_i && !idx_last && !stall;

  // r<<2 for the B address.
  bitrev_perm_seq_bitreverse #(.Width(MaxLogN)) u_rev_addr (
    .data_i   (idx_q[MaxLogN-1:0]),
    .log_n_i  (log_n_q),
    .op_i     (BitrevOpPqShift),
    .result_o (r_x4)
  );

  // Plain r for the i < r ordering test.
  bitrev_perm_seq_bitreverse #(.Width(MaxLogN)) u_rev_cmp (
    .data_i   (idx_q[MaxLogN-1:0]),
    .log_n_i  (log_n_q),
    .op_i     (BitrevOpPlain),
    .result_o (r_plain_w)
  );

  // Plain mode leaves the top two result bits zero.
  assign r_plain = r_plain_w[MaxLogN-1:0];
  assign is_pair = idx_q[MaxLogN-1:0] < r_plain;

  // Only the i < r half is emitted so each swap appears once and self-maps are skipped.
  assign pair_d.addr_a = base_q + {{(30-IdxW){1'b0}}, idx_q, 2'b00};
  assign pair_d.addr_b = base_q + {{(30-MaxLogN){1'b0}}, r_x4};

  // Next-state and status decode; clear overrides everything.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    err_d    = 1'b0;
    done_o   = 1'b0;
    busy_o   = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_ok) begin
            state_d  = RUN;
            start_ok = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (idx_last && !stall) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d  = IDLE;
      start_ok = 1'b0;
      err_d    = 1'b0;
      done_o   = 1'b0;
    end
  end

  // State, run configuration and index walker.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      log_n_q <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_o   <= err_d;
      if (start_ok) begin
        log_n_q <= log_n_i;
        base_q  <= base_addr_i;
        idx_q   <= '0;
      end else if (eval) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // Output register: load on a valid pair, hold under backpressure, empty on transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pair_valid_o <= 1'b0;
      addr_a_o     <= '0;
      addr_b_o     <= '0;
    end else if (clear_i) begin
      pair_valid_o <= 1'b0;
    end else if (eval && is_pair) begin
      pair_valid_o <= 1'b1;
      addr_a_o     <= pair_d.addr_a;
      addr_b_o     <= pair_d.addr_b;
    end else if (fire) begin
      pair_valid_o <= 1'b0;
    end
  end

`ifdef BITREV_SEQ_PAIR_CNT_EN
  logic [11:0] pair_cnt_q;

  // Count accepted transfers; restart on each accepted start, keep value on clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       pair_cnt_q <= '0;
    else if (start_ok) pair_cnt_q <= '0;
    else if (fire)     pair_cnt_q <= pair_cnt_q + 12'd1;
  end

  assign pair_cnt_o = pair_cnt_q;
`else
  assign pair_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bitrev_perm_seq.sv
// Bench for bitrev_perm_seq: table of runs checked against a scoreboard of
// expected pairs, plus hand sequences for clear, reset and busy-start cases.
module tb_bitrev_perm_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0, clear_i = 1'b0, pair_ready_i = 1'b0;
  logic [3:0]  log_n_i = '0;
  logic [31:0] base_i = '0;
  logic        pair_valid_o, busy_o, done_o, err_o;
  logic [31:0] addr_a_o, addr_b_o;
  logic [11:0] pair_cnt_o;

  bitrev_perm_seq dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .clear_i(clear_i),
    .log_n_i(log_n_i), .base_addr_i(base_i), .pair_valid_o(pair_valid_o),
    .pair_ready_i(pair_ready_i), .addr_a_o(addr_a_o), .addr_b_o(addr_b_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .pair_cnt_o(pair_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct { int log_n; logic [31:0] base; int mode; int exp_pairs; bit exp_err; } vec_t;
  typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;

  pair_t sb[$];
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_cnt(input int n);
`ifdef BITREV_SEQ_PAIR_CNT_EN
    return 12'(n);
`else
    return 12'd0 + 0 * n;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Expected pairs straight from the definition: reverse the low log_n bits of i.
  task automatic build_sb(input int log_n, input logic [31:0] base);
    int r;
    sb.delete();
    for (int i = 0; i < (1 << log_n); i++) begin
      r = 0;
      for (int b = 0; b < log_n; b++) if (i[b]) r |= 1 << (log_n - 1 - b);
      if (i < r) sb.push_back('{base + 32'(i * 4), base + 32'(r * 4)});
    end
  endtask

  task automatic pop_chk();
    pair_t p;
    if (sb.size() == 0) begin
      chk("extra_pair", {8'h0, addr_a_o, addr_b_o}, 72'h0);
    end else begin
      p = sb.pop_front();
      chk("pair", {8'h0, addr_a_o, addr_b_o}, {8'h0, p.a, p.b});
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc_n, got, first, budget;
    bit done_seen, prev_stall, rdy, any_act;
    logic [31:0] pa, pb;
    build_sb(v.log_n, v.base);
    start_i = 1'b1; log_n_i = 4'(v.log_n); base_i = v.base; pair_ready_i = 1'b1;
    cyc();
    start_i = 1'b0;
    if (v.exp_err) begin
      chk("err_pulse", {70'h0, err_o, busy_o}, {70'h0, 1'b1, 1'b0});
      any_act = 1'b0;
      cyc();
      chk("err_one_cycle", {71'h0, err_o}, 72'h0);
      repeat (5) begin
        any_act |= pair_valid_o | busy_o | err_o | done_o;
        cyc();
      end
      chk("err_no_activity", {71'h0, any_act}, 72'h0);
      return;
    end
    chk("busy_after_start", {71'h0, busy_o}, 72'h1);
    budget = (1 << v.log_n) * 4 + 50;
    cyc_n = 0; got = 0; first = -1; done_seen = 0; prev_stall = 0; pa = '0; pb = '0;
    while (cyc_n < budget) begin
      if (prev_stall)
        chk("stall_hold", {7'h0, pair_valid_o, addr_a_o, addr_b_o}, {7'h0, 1'b1, pa, pb});
      if (done_o) begin done_seen = 1; break; end
      if (cyc_n == 6) chk("start_ignored_busy", {71'h0, err_o}, 72'h0);
      start_i = (cyc_n == 5);
      log_n_i = (cyc_n == 5) ? 4'd13 : 4'(v.log_n);
      if (pair_valid_o && first < 0) first = cyc_n;
      rdy = (v.mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      pair_ready_i = rdy;
      if (pair_valid_o && rdy) begin pop_chk(); got++; end
      prev_stall = pair_valid_o && !rdy;
      pa = addr_a_o; pb = addr_b_o;
      cyc(); cyc_n++;
    end
    start_i = 1'b0;
    chk("done_seen", {71'h0, done_seen}, 72'h1);
    chk("first_latency", 72'(first), 72'd2);
    chk("pair_total", 72'(got), 72'(v.exp_pairs));
    chk("sb_empty", 72'(sb.size()), 72'd0);
    chk("cnt_at_done", {60'h0, pair_cnt_o}, {60'h0, exp_cnt(v.exp_pairs)});
    chk("busy_in_done", {71'h0, busy_o}, 72'h1);
    cyc();
    chk("idle_after_done", {70'h0, busy_o, done_o}, 72'h0);
  endtask

  vec_t vecs[8];

  initial begin
    int got, guard;
    bit any_done;
    vecs[0] = '{6,  32'h0000_1000, 0, 28,   0};
    vecs[1] = '{7,  32'h0000_2000, 0, 56,   0};
    vecs[2] = '{8,  32'h0000_0000, 0, 120,  0};
    vecs[3] = '{8,  32'h0000_0000, 1, 120,  0};
    vecs[4] = '{12, 32'h4000_0000, 0, 2016, 0};
    vecs[5] = '{5,  32'h0000_1000, 0, 0,    1};
    vecs[6] = '{13, 32'h0000_1000, 0, 0,    1};
    vecs[7] = '{6,  32'hFFFF_FFF0, 0, 28,   0};

    // Reset state.
    #3;
    chk("reset_outs", {3'h0, pair_valid_o, busy_o, done_o, err_o, 1'b0, addr_a_o, addr_b_o},
        72'h0);
    chk("reset_cnt", {60'h0, pair_cnt_o}, 72'h0);
    #4 rst_n = 1'b1;
    cyc();

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Clear after 10 transfers of a log_n=9 run.
    build_sb(9, 32'h0008_0000);
    start_i = 1'b1; log_n_i = 4'd9; base_i = 32'h0008_0000; pair_ready_i = 1'b1;
    cyc();
    start_i = 1'b0; got = 0; guard = 0;
    while (got < 10 && guard < 500) begin
      if (pair_valid_o) begin pop_chk(); got++; end
      cyc(); guard++;
    end
    chk("clear_reached_10", 72'(got), 72'd10);
    pair_ready_i = 1'b0; clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    chk("clear_idle", {69'h0, busy_o, pair_valid_o, done_o}, 72'h0);
    chk("clear_cnt_kept", {60'h0, pair_cnt_o}, {60'h0, exp_cnt(10)});
    any_done = 1'b0;
    repeat (4) begin any_done |= done_o | busy_o; cyc(); end
    chk("clear_no_done", {71'h0, any_done}, 72'h0);
    run_vec(vecs[0]);

    // Asynchronous reset mid-run.
    start_i = 1'b1; log_n_i = 4'd6; base_i = 32'hFFFF_FFF0; pair_ready_i = 1'b1;
    cyc();
    start_i = 1'b0; guard = 0;
    while (!pair_valid_o && guard < 20) begin cyc(); guard++; end
    chk("rst_run_active", {70'h0, pair_valid_o, busy_o}, {70'h0, 1'b1, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {3'h0, pair_valid_o, busy_o, done_o, err_o, 1'b0, addr_a_o, addr_b_o},
        72'h0);
    chk("async_rst_cnt", {60'h0, pair_cnt_o}, 72'h0);
    #2 rst_n = 1'b1;
    any_done = 1'b0;
    repeat (3) begin cyc(); any_done |= done_o | busy_o; end
    chk("rst_no_done", {71'h0, any_done}, 72'h0);

    // Address wrap at the top of the 32-bit space.
    run_vec(vecs[7]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bitrev_perm_seq.md
BITREV_PERM_SEQ -- requirements
Module: bitrev_perm_seq

Interface
REQ-001 SHALL have parameter MinLogN, default 6, smallest legal log2 transform length.
REQ-002 SHALL have parameter MaxLogN, default 12, largest legal log2 transform length.
REQ-003 SHALL have ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  start request; sampled in IDLE only.
- clear_i  in  1  synchronous abort to IDLE.
- log_n_i  in  4  log2 of transform length; sampled with start_i.
- base_addr_i  in  32  byte base address; sampled with start_i.
- pair_valid_o  out  1  swap pair valid.
- pair_ready_i  in  1  consumer accepts pair.
- addr_a_o  out  32  base + 4*i.
- addr_b_o  out  32  base + 4*bitrev(i).
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle illegal-length pulse.
- pair_cnt_o  out  12  pairs accepted in the current or last run.

Function
REQ-004 SHALL implement FSM states IDLE, RUN, DONE.
REQ-005 IDLE + start_i with MinLogN<=log_n_i<=MaxLogN SHALL latch log_n and base, clear index i to 0, and enter RUN next cycle.
REQ-006 IDLE + start_i with illegal log_n_i SHALL pulse err_o for the next cycle only and remain in IDLE.
REQ-007 start_i outside IDLE SHALL be ignored.
REQ-008 In RUN, each cycle without stall SHALL evaluate i, compute r = bitrev(i, log_n), and increment i.
REQ-009 When i < r, SHALL load the output register at the clock edge: addr_a_o = base + (i<<2), addr_b_o = base + (r<<2), pair_valid_o = 1.
REQ-010 When i >= r, SHALL produce no output for that index (skip).
REQ-011 Address additions SHALL wrap modulo 2^32.
REQ-012 Output register SHALL hold while pair_valid_o && !pair_ready_i, and index evaluation SHALL stall in that cycle.
REQ-013 With pair_ready_i held high, SHALL sustain one pair per cycle.
REQ-014 Latency: an index evaluated in cycle k SHALL appear on the outputs in cycle k+1.
REQ-015 A pair SHALL be transferred only on pair_valid_o && pair_ready_i, and pair_cnt_o SHALL increment on each transfer.
REQ-016 After index 2^log_n - 1 is evaluated and the output register is empty or transferring, SHALL enter DONE.
REQ-017 DONE SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-018 busy_o SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-019 clear_i SHALL take priority in any state: go to IDLE next cycle, drop any pending pair, suppress done_o; pair_cnt_o retains its value.
REQ-020 addr_a_o and addr_b_o SHALL hold their last value when pair_valid_o is 0.
REQ-021 pair_cnt_o SHALL clear on each accepted start.

Reset
REQ-022 rst_ni low SHALL asynchronously force: state IDLE, i=0, pair_valid_o=0, addr_a_o=0, addr_b_o=0, busy_o=0, done_o=0, err_o=0, pair_cnt_o=0.
REQ-023 Reset mid-run SHALL discard the run with no done_o pulse.

Configuration
REQ-024 With BITREV_SEQ_PAIR_CNT_EN defined, SHALL implement the pair counter per REQ-015 and REQ-021.
REQ-025 Without BITREV_SEQ_PAIR_CNT_EN, pair_cnt_o SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-026 otbn_pq_pkg SHALL hold: enum bitrev_seq_state_e (IDLE/RUN/DONE) and constants BitrevSeqMinLogN=6, BitrevSeqMaxLogN=12.
REQ-027 SHALL instantiate the existing bitreverse sub-module twice:
- once with op BitrevOpPqShift on r, to form 4*r;
- once in plain mode as the i<r comparator source.
4*i SHALL be formed locally.

Verification
REQ-028 log_n=6, base=0x1000, ready=1 -> first pair (0x1004, 0x1080); exactly 28 pairs; done_o pulse; pair_cnt_o=28.
REQ-029 log_n=12, ready=1 -> 2016 pairs; no pair with a==b; each unordered pair emitted once; log_n=7 -> 56, log_n=8 -> 120.
REQ-030 log_n=8 with random ready backpressure -> identical pair sequence to ready=1; outputs stable while stalled.
REQ-031 log_n=5 or 13 with start_i -> err_o high one cycle; busy_o stays 0; no pairs.
REQ-032 clear_i after 10 pairs (log_n=9) -> IDLE next cycle; pair_valid_o=0; no done_o; pair_cnt_o=10; new start runs cleanly.
REQ-033 rst_ni low mid-run -> all outputs 0 immediately, without a clock edge; base=0xFFFFFFF0, log_n=6 -> addresses wrap modulo 2^32.
